// File: rtl/balance_cntrl_pipe.sv
// Two-stage balance controller: PID + soft-start + steering mix + saturation + overspeed, 2-clk latency.
// Optional output slew limiter enabled by defining BALANCE_CNTRL_RATE_LIMIT_EN.
module balance_cntrl_pipe #(
   parameter bit FAST_SIM     = 1'b1,
   parameter int SPD_W        = 12,
   parameter int P_COEF       = 9,
   parameter int TOO_FAST_THR = 1536,
   parameter int SLEW_MAX     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [15:0]       ptch,
   input  logic signed [15:0]       ptch_rt,
   input  logic                     vld,
   input  logic                     pwr_up,
   input  logic                     rider_off,
   input  logic [11:0]              steer_pot,
   input  logic                     en_steer,
   output logic signed [SPD_W-1:0]  lft_spd,
   output logic signed [SPD_W-1:0]  rght_spd,
   output logic                     too_fast,
   output logic                     spd_vld
);

   localparam logic signed [5:0] P_COEF_S = 6'(P_COEF);
   localparam logic [15:0]       SS_INC   = FAST_SIM ? 16'd256 : 16'd1;
   localparam int                SPD_MAX  = (2 ** (SPD_W - 1)) - 1;
   localparam int                SPD_MIN  = -(2 ** (SPD_W - 1));

   logic signed [17:0]      integ_q, integ_d;
   logic [15:0]             ss_tmr_q, ss_tmr_d;
   logic signed [11:0]      pid_p1_q, pid_p1_d;
   logic signed [SPD_W-1:0] lft_q, lft_d, rght_q, rght_d;
   logic                    too_fast_q, too_fast_d;
   logic                    vld_d1_q, vld_d2_q;

   logic signed [9:0]       ptch_sat;
   logic signed [14:0]      p_term;
   logic signed [15:0]      i_term, d_term;
   logic signed [16:0]      pid_sum;
   logic signed [18:0]      integ_sum;
   logic signed [8:0]       ss_gain;
   logic signed [20:0]      prod;
   logic signed [11:0]      scaled;
   logic [11:0]             steer_clip;
   logic signed [12:0]      steer_off;
   logic signed [14:0]      steer_mul, steer;
   logic signed [13:0]      lft_w, rght_w;
   logic signed [SPD_W-1:0] lft_tgt, rght_tgt;

   function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [13:0] v);
      if (int'(v) > SPD_MAX) return SPD_W'(SPD_MAX);
      if (int'(v) < SPD_MIN) return SPD_W'(SPD_MIN);
      return SPD_W'(v);
   endfunction

`ifdef BALANCE_CNTRL_RATE_LIMIT_EN
   function automatic logic signed [SPD_W-1:0] slew(input logic signed [SPD_W-1:0] cur,
                                                     input logic signed [SPD_W-1:0] tgt);
      int diff;
      diff = int'(tgt) - int'(cur);
      if (diff > SLEW_MAX) diff = SLEW_MAX;
      else if (diff < -SLEW_MAX) diff = -SLEW_MAX;
      return SPD_W'(int'(cur) + diff);
   endfunction
`endif

   // Stage 1: PID terms and integrator/soft-start state
   always_comb begin
      ptch_sat = ptch[9:0];
      if (ptch > 16'sd511) ptch_sat = 10'sd511;
      else if (ptch < -16'sd512) ptch_sat = -10'sd512;

      p_term = 15'(ptch_sat) * 15'(P_COEF_S);
      i_term = 16'(FAST_SIM ? (integ_q >>> 1) : (integ_q >>> 4));
      d_term = -(ptch_rt >>> 6);

      pid_sum  = 17'(p_term) + 17'(i_term) + 17'(d_term);
      pid_p1_d = pid_sum[11:0];
      if (pid_sum > 17'sd2047) pid_p1_d = 12'sd2047;
      else if (pid_sum < -17'sd2048) pid_p1_d = -12'sd2048;

      // Overflowing accumulation keeps the old value rather than wrapping
      integ_sum = {integ_q[17], integ_q} + 19'(ptch_sat);
      integ_d   = integ_q;
      if (rider_off) integ_d = '0;
      else if (vld && (integ_sum[18] == integ_sum[17])) integ_d = integ_sum[17:0];

      ss_tmr_d = ss_q_next(ss_tmr_q);
   end

   function automatic logic [15:0] ss_q_next(input logic [15:0] cur);
      if (!pwr_up) return '0;
      if (cur > 16'hFFFF - SS_INC) return 16'hFFFF;
      return cur + SS_INC;
   endfunction

   // Stage 2: soft-start scaling, steering mix, saturation
   always_comb begin
      ss_gain = {1'b0, ss_tmr_q[15:8]};
      prod    = 21'(pid_p1_q) * 21'(ss_gain);
      scaled  = 12'(prod >>> 8);

      steer_clip = steer_pot;
      if (steer_pot < 12'h200) steer_clip = 12'h200;
      else if (steer_pot > 12'hE00) steer_clip = 12'hE00;
      steer_off = $signed({1'b0, steer_clip}) - 13'sd2047;
      steer_mul = 15'(steer_off) * 15'sd3;
      steer     = steer_mul >>> 4;

      lft_w  = 14'(scaled);
      rght_w = 14'(scaled);
      if (en_steer) begin
         lft_w  = 14'(scaled) + 14'(steer);
         rght_w = 14'(scaled) - 14'(steer);
      end

      lft_tgt  = pwr_up ? sat_spd(lft_w)  : '0;
      rght_tgt = pwr_up ? sat_spd(rght_w) : '0;
      too_fast_d = (int'(lft_tgt) > TOO_FAST_THR) || (int'(rght_tgt) > TOO_FAST_THR);

`ifdef BALANCE_CNTRL_RATE_LIMIT_EN
      lft_d  = lft_q;
      rght_d = rght_q;
      if (!pwr_up) begin
         lft_d  = '0;
         rght_d = '0;
      end else if (vld_d1_q) begin
         lft_d  = slew(lft_q, lft_tgt);
         rght_d = slew(rght_q, rght_tgt);
      end
`else
      lft_d  = lft_tgt;
      rght_d = rght_tgt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         integ_q    <= '0;
         ss_tmr_q   <= '0;
         pid_p1_q   <= '0;
         lft_q      <= '0;
         rght_q     <= '0;
         too_fast_q <= 1'b0;
         vld_d1_q   <= 1'b0;
         vld_d2_q   <= 1'b0;
      end else begin
         integ_q    <= integ_d;
         ss_tmr_q   <= ss_tmr_d;
         pid_p1_q   <= pid_p1_d;
         lft_q      <= lft_d;
         rght_q     <= rght_d;
         too_fast_q <= too_fast_d;
         vld_d1_q   <= vld;
         vld_d2_q   <= vld_d1_q;
      end
   end

   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign too_fast = too_fast_q;
   assign spd_vld  = vld_d2_q;

endmodule
